// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: bypasses the register file read data with in-flight
// EX/MEM/WB results, detects load-use hazards and registers operands and
// control into the EX stage.
module id_ex_operand_stage #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int R0_IS_ZERO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [DW-1:0]    instr_id,
  input  logic [AW-1:0]    AA,
  input  logic [AW-1:0]    BA,
  input  logic             uses_a,
  input  logic             uses_b,
  input  logic [AW-1:0]    DA_id,
  input  logic             RW_id,
  input  logic             MR_id,
  input  logic [DW-1:0]    A_data,
  input  logic [DW-1:0]    B_data,
  input  logic [DW-1:0]    ex_result,
  input  logic [AW-1:0]    mem_DA,
  input  logic             mem_RW,
  input  logic [DW-1:0]    mem_result,
  input  logic [AW-1:0]    wb_DA,
  input  logic             wb_RW,
  input  logic [DW-1:0]    BUS_D,
  input  logic             flush,
  input  logic             hold,
  output logic [DW-1:0]    A_ex,
  output logic [DW-1:0]    B_ex,
  output logic [DW-1:0]    instr_ex,
  output logic [AW-1:0]    DA_ex,
  output logic             RW_ex,
  output logic             MR_ex,
  output logic             valid_ex,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [AW-1:0] src_addr [2];
  logic [DW-1:0] rf_val   [2];
  logic [1:0]    src_used;
  logic [DW-1:0] a_fwd;
  logic [DW-1:0] b_fwd;
  logic          lu;

  assign src_addr[0] = AA;
  assign src_addr[1] = BA;
  assign rf_val[0]   = A_data;
  assign rf_val[1]   = B_data;
  assign src_used    = {uses_b, uses_a};

  // An ALU result in EX is usable now; a load in EX is not (its data
  // only exists once it reaches MEM), which is what the hazard covers.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic          src_zero;
      logic          lu_src;
      logic [DW-1:0] val;

      assign src_zero = (R0_IS_ZERO != 0) && (src_addr[gi] == '0);
      assign lu_src   = src_used[gi] && (DA_ex == src_addr[gi]) && !src_zero;

      // Bypass priority: youngest producer wins, WB covers the write-then-read edge.
      always_comb begin
        if (src_zero)
          val = '0;
        else if (valid_ex && RW_ex && !MR_ex && (DA_ex == src_addr[gi]))
          val = ex_result;
        else if (mem_RW && (mem_DA == src_addr[gi]))
          val = mem_result;
        else if (wb_RW && (wb_DA == src_addr[gi]))
          val = BUS_D;
        else
          val = rf_val[gi];
      end
    end
  endgenerate

  assign a_fwd = g_fwd[0].val;
  assign b_fwd = g_fwd[1].val;

  assign lu    = valid_id && valid_ex && MR_ex && RW_ex && (g_fwd[0].lu_src || g_fwd[1].lu_src);
  assign stall = (lu || hold) && !flush;

  // ID/EX register: flush beats hold, hold beats the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_ex      <= '0;
      B_ex      <= '0;
      instr_ex  <= '0;
      DA_ex     <= '0;
      RW_ex     <= 1'b0;
      MR_ex     <= 1'b0;
      valid_ex  <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      valid_ex <= 1'b0;
      RW_ex    <= 1'b0;
      MR_ex    <= 1'b0;
    end else if (hold) begin
      valid_ex <= valid_ex;
    end else if (lu) begin
      valid_ex <= 1'b0;
      RW_ex    <= 1'b0;
      MR_ex    <= 1'b0;
      if (stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end else begin
      A_ex     <= a_fwd;
      B_ex     <= b_fwd;
      instr_ex <= instr_id;
      DA_ex    <= DA_id;
      valid_ex <= valid_id;
      RW_ex    <= RW_id && valid_id;
      MR_ex    <= MR_id && valid_id;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding priority, load-use
// bubbles, flush/hold precedence, reset and the R0-as-zero variant.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_id;
  logic [DW-1:0] instr_id;
  logic [AW-1:0] AA, BA, DA_id, mem_DA, wb_DA;
  logic          uses_a, uses_b, RW_id, MR_id, mem_RW, wb_RW, flush, hold;
  logic [DW-1:0] A_data, B_data, ex_result, mem_result, BUS_D;

  logic [DW-1:0] A_ex, B_ex, instr_ex;
  logic [AW-1:0] DA_ex;
  logic          RW_ex, MR_ex, valid_ex, stall;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] z_A_ex, z_B_ex, z_instr_ex;
  logic [AW-1:0] z_DA_ex;
  logic          z_RW_ex, z_MR_ex, z_valid_ex, z_stall;
  logic [1:0]    z_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .AW(AW), .R0_IS_ZERO(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .instr_id(instr_id),
    .AA(AA), .BA(BA), .uses_a(uses_a), .uses_b(uses_b),
    .DA_id(DA_id), .RW_id(RW_id), .MR_id(MR_id),
    .A_data(A_data), .B_data(B_data), .ex_result(ex_result),
    .mem_DA(mem_DA), .mem_RW(mem_RW), .mem_result(mem_result),
    .wb_DA(wb_DA), .wb_RW(wb_RW), .BUS_D(BUS_D),
    .flush(flush), .hold(hold),
    .A_ex(A_ex), .B_ex(B_ex), .instr_ex(instr_ex), .DA_ex(DA_ex),
    .RW_ex(RW_ex), .MR_ex(MR_ex), .valid_ex(valid_ex),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  id_ex_operand_stage #(.DW(DW), .AW(AW), .R0_IS_ZERO(1), .CNT_W(2)) dut_z (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .instr_id(instr_id),
    .AA(AA), .BA(BA), .uses_a(uses_a), .uses_b(uses_b),
    .DA_id(DA_id), .RW_id(RW_id), .MR_id(MR_id),
    .A_data(A_data), .B_data(B_data), .ex_result(ex_result),
    .mem_DA(mem_DA), .mem_RW(mem_RW), .mem_result(mem_result),
    .wb_DA(wb_DA), .wb_RW(wb_RW), .BUS_D(BUS_D),
    .flush(flush), .hold(hold),
    .A_ex(z_A_ex), .B_ex(z_B_ex), .instr_ex(z_instr_ex), .DA_ex(z_DA_ex),
    .RW_ex(z_RW_ex), .MR_ex(z_MR_ex), .valid_ex(z_valid_ex),
    .stall(z_stall), .stall_cnt(z_stall_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_id = 0; instr_id = '0; AA = '0; BA = '0; uses_a = 0; uses_b = 0;
    DA_id = '0; RW_id = 0; MR_id = 0; A_data = '0; B_data = '0;
    ex_result = '0; mem_DA = '0; mem_RW = 0; mem_result = '0;
    wb_DA = '0; wb_RW = 0; BUS_D = '0; flush = 0; hold = 0;
  endtask

  // Presents one ID-stage instruction.
  task automatic set_id(input logic [DW-1:0] ins, input logic [AW-1:0] da, input logic rw,
                        input logic mr, input logic [AW-1:0] aa, input logic ua,
                        input logic [AW-1:0] ba, input logic ub);
    valid_id = 1; instr_id = ins; DA_id = da; RW_id = rw; MR_id = mr;
    AA = aa; uses_a = ua; BA = ba; uses_b = ub;
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    // 1. Reset
    #2;
    chk("rst_A_ex", A_ex, 0);
    chk("rst_B_ex", B_ex, 0);
    chk("rst_valid_ex", {31'd0, valid_ex}, 0);
    chk("rst_RW_MR", {30'd0, RW_ex, MR_ex}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("idle_valid_ex", {31'd0, valid_ex}, 0);

    // 2. EX forward: ADD R3 goes to EX, next instruction reads R3
    set_id(32'h0000_1003, 5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    tick();
    chk("add_valid_ex", {31'd0, valid_ex}, 1);
    chk("add_DA_ex", {27'd0, DA_ex}, 3);
    chk("add_instr_ex", instr_ex, 32'h0000_1003);
    set_id(32'h0000_2004, 5'd4, 1, 0, 5'd3, 1, 5'd0, 0);
    A_data = 32'h0; ex_result = 32'h11;
    #1 chk("exfwd_stall", {31'd0, stall}, 0);
    tick();
    chk("exfwd_A_ex", A_ex, 32'h11);

    // 3. Priority on B: EX(0xA) > MEM(0xB) > WB(0xC) > file(0xD)
    set_id(32'h0000_3005, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    set_id(32'h0000_4000, 5'd5, 0, 0, 5'd0, 0, 5'd5, 1);
    ex_result = 32'hA; mem_DA = 5'd5; mem_RW = 1; mem_result = 32'hB;
    wb_DA = 5'd5; wb_RW = 1; BUS_D = 32'hC; B_data = 32'hD;
    tick();
    chk("prio_ex", B_ex, 32'hA);
    chk("prio_RW_ex_off", {31'd0, RW_ex}, 0);
    tick();
    chk("prio_mem", B_ex, 32'hB);
    mem_RW = 0;
    tick();
    chk("prio_wb", B_ex, 32'hC);
    wb_RW = 0;
    tick();
    chk("prio_file", B_ex, 32'hD);

    // 4. Load-use: LD R2 then a reader of R2
    clr_in();
    set_id(32'h0000_5002, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0);
    tick();
    chk("ld_MR_ex", {31'd0, MR_ex}, 1);
    set_id(32'h0000_6006, 5'd6, 1, 0, 5'd2, 1, 5'd0, 0);
    ex_result = 32'hDEAD;
    #1 chk("lu_stall", {31'd0, stall}, 1);
    tick();
    chk("lu_bubble_valid", {31'd0, valid_ex}, 0);
    chk("lu_bubble_RW_MR", {30'd0, RW_ex, MR_ex}, 0);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 1);
    chk("lu_stall_gone", {31'd0, stall}, 0);
    mem_DA = 5'd2; mem_RW = 1; mem_result = 32'h77;
    tick();
    chk("lu_memfwd_A", A_ex, 32'h77);
    chk("lu_use_valid", {31'd0, valid_ex}, 1);
    chk("lu_use_DA", {27'd0, DA_ex}, 6);
    chk("lu_stall_cnt_hold", {16'd0, stall_cnt}, 1);

    // 5. Flush with a pending hazard
    clr_in();
    set_id(32'h0000_5002, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0);
    tick();
    set_id(32'h0000_6006, 5'd6, 1, 0, 5'd2, 1, 5'd0, 0);
    flush = 1;
    #1 chk("flush_stall", {31'd0, stall}, 0);
    tick();
    chk("flush_valid", {31'd0, valid_ex}, 0);
    chk("flush_RW_MR", {30'd0, RW_ex, MR_ex}, 0);
    chk("flush_stall_cnt", {16'd0, stall_cnt}, 1);

    // Hold freezes ID/EX; flush still wins over hold
    clr_in();
    set_id(32'h0000_7007, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    set_id(32'h0000_8008, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0);
    hold = 1;
    #1 chk("hold_stall", {31'd0, stall}, 1);
    tick();
    chk("hold_instr_kept", instr_ex, 32'h0000_7007);
    chk("hold_RW_kept", {31'd0, RW_ex}, 1);
    flush = 1;
    tick();
    chk("flush_over_hold", {31'd0, valid_ex}, 0);

    // Asynchronous reset mid-operation with a hazard pending
    clr_in();
    set_id(32'h0000_5002, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0);
    tick();
    set_id(32'h0000_6006, 5'd6, 1, 0, 5'd2, 1, 5'd0, 0);
    #1 chk("pre_rst_stall", {31'd0, stall}, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_valid", {31'd0, valid_ex}, 0);
    chk("midrst_instr", instr_ex, 0);
    chk("midrst_stall", {31'd0, stall}, 0);
    chk("midrst_cnt", {16'd0, stall_cnt}, 0);
    tick();
    rst_n = 1;
    #1 chk("post_rst_stall", {31'd0, stall}, 0);
    tick();
    chk("post_rst_issue", {27'd0, DA_ex}, 6);

    // Saturation: four load-use bubbles; 2-bit counter stops at 3
    for (int i = 0; i < 4; i++) begin
      set_id(32'h0000_5002, 5'd2, 1, 1, 5'd0, 0, 5'd0, 0);
      tick();
      set_id(32'h0000_6006, 5'd6, 1, 0, 5'd0, 0, 5'd2, 1);
      tick();
    end
    chk("sat_cnt16", {16'd0, stall_cnt}, 4);
    chk("sat_cnt2", {30'd0, z_stall_cnt}, 3);

    // 6. R0 handling: load to R0 in EX, WB writes R0=5, reader of R0
    clr_in();
    set_id(32'h0000_9000, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    tick();
    set_id(32'h0000_A007, 5'd7, 1, 0, 5'd0, 1, 5'd0, 0);
    wb_DA = 5'd0; wb_RW = 1; BUS_D = 32'h5; A_data = 32'h99;
    #1;
    chk("r0z_no_stall", {31'd0, z_stall}, 0);
    chk("r0_plain_stall", {31'd0, stall}, 1);
    tick();
    chk("r0z_A_ex", z_A_ex, 0);
    chk("r0z_valid", {31'd0, z_valid_ex}, 1);
    chk("r0_plain_bubble", {31'd0, valid_ex}, 0);
    tick();
    chk("r0_plain_wbfwd", A_ex, 32'h5);
    chk("r0z_A_ex_again", z_A_ex, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
